// File: rtl/cpsr_unit_pkg.sv
// Shared defines for the CPSR unit: flag-setting op codes, flag bit indices,
// branch condition codes with their evaluation helper, and the exception FSM states.
package cpsr_unit_pkg;

  localparam logic [2:0] FOP_NONE  = 3'd0;
  localparam logic [2:0] FOP_ADD   = 3'd1;
  localparam logic [2:0] FOP_SUB   = 3'd2;
  localparam logic [2:0] FOP_LOGIC = 3'd3;
  localparam logic [2:0] FOP_LOAD  = 3'd4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] COND_JMP = 3'd0;
  localparam logic [2:0] COND_JEQ = 3'd1;
  localparam logic [2:0] COND_JNE = 3'd2;
  localparam logic [2:0] COND_JGT = 3'd3;
  localparam logic [2:0] COND_JGE = 3'd4;
  localparam logic [2:0] COND_JLT = 3'd5;
  localparam logic [2:0] COND_JLE = 3'd6;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_EXC    = 1'b1
  } exc_state_e;

  // Signed comparisons after a SUB: "greater or equal" means N==V.
  function automatic logic cond_taken(input logic [2:0] cond, input logic [3:0] f);
    logic ge;
    ge = (f[FLAG_N] == f[FLAG_V]);
    case (cond)
      COND_JMP: cond_taken = 1'b1;
      COND_JEQ: cond_taken = f[FLAG_Z];
      COND_JNE: cond_taken = ~f[FLAG_Z];
      COND_JGT: cond_taken = ge & ~f[FLAG_Z];
      COND_JGE: cond_taken = ge;
      COND_JLT: cond_taken = ~ge;
      COND_JLE: cond_taken = ~ge | f[FLAG_Z];
      default:  cond_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpsr_unit_flag_calc.sv
// Combinational flag arithmetic: produces the flag word a flag write would
// store, given the current flags. Unused op codes return the current flags.
module flag_calc
  import cpsr_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        flag_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] logic_res,
  input  logic [3:0]        cpsr_wdata,
  input  logic [3:0]        cpsr_cur,
  output logic [3:0]        flags_new
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            a_msb;
  logic            b_msb;

  assign sum   = {1'b0, op_a} + {1'b0, op_b};
  assign diff  = {1'b0, op_a} - {1'b0, op_b};
  assign a_msb = op_a[DATA_W-1];
  assign b_msb = op_b[DATA_W-1];

  always_comb begin
    flags_new = cpsr_cur;
    case (flag_op)
      FOP_ADD: begin
        flags_new[FLAG_N] = sum[DATA_W-1];
        flags_new[FLAG_Z] = ~|sum[DATA_W-1:0];
        flags_new[FLAG_C] = sum[DATA_W];
        flags_new[FLAG_V] = (a_msb == b_msb) && (sum[DATA_W-1] != a_msb);
      end
      FOP_SUB: begin
        flags_new[FLAG_N] = diff[DATA_W-1];
        flags_new[FLAG_Z] = ~|diff[DATA_W-1:0];
        // Borrow out of the extended subtraction is the inverse of carry.
        flags_new[FLAG_C] = ~diff[DATA_W];
        flags_new[FLAG_V] = (a_msb != b_msb) && (diff[DATA_W-1] != a_msb);
      end
      FOP_LOGIC: begin
        flags_new[FLAG_N] = logic_res[DATA_W-1];
        flags_new[FLAG_Z] = ~|logic_res;
      end
      FOP_LOAD: flags_new = cpsr_wdata;
      default:  flags_new = cpsr_cur;
    endcase
  end

endmodule

// File: rtl/cpsr_unit.sv
// Condition flag register {N,Z,C,V} with one-level exception save/restore (SPSR).
// Optional same-cycle forwarding of the next flag value under macro CPSR_FWD_EN.
module cpsr_unit
  import cpsr_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic [2:0]        flag_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] logic_res,
  input  logic [3:0]        cpsr_wdata,
  input  logic              exc_enter,
  input  logic              exc_return,
  output logic [3:0]        cpsr_out,
  output logic [3:0]        cpsr_fwd,
  output logic [3:0]        spsr_out,
  output logic              in_exc,
  output logic              exc_err
);

  exc_state_e state_q, state_d;
  logic [3:0] cpsr_q, cpsr_d;
  logic [3:0] spsr_q, spsr_d;
  logic       err_q, err_d;
  logic [3:0] flags_new;
  logic [3:0] flags_wr;
  logic       legal_enter;
  logic       legal_return;

  flag_calc #(.DATA_W(DATA_W)) u_flag_calc (
    .flag_op    (flag_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .logic_res  (logic_res),
    .cpsr_wdata (cpsr_wdata),
    .cpsr_cur   (cpsr_q),
    .flags_new  (flags_new)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      cpsr_q  <= 4'b0000;
      spsr_q  <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cpsr_q  <= cpsr_d;
      spsr_q  <= spsr_d;
      err_q   <= err_d;
    end
  end

  // Enter and return together is an error; a legal return wins over a flag write,
  // while a legal enter saves the freshly computed flags.
  always_comb begin
    flags_wr     = flag_we ? flags_new : cpsr_q;
    legal_enter  = exc_enter && !exc_return && (state_q == ST_NORMAL);
    legal_return = exc_return && !exc_enter && (state_q == ST_EXC);
    err_d        = (exc_enter && exc_return) ||
                   (exc_enter && (state_q == ST_EXC)) ||
                   (exc_return && (state_q == ST_NORMAL));
    state_d      = state_q;
    cpsr_d       = flags_wr;
    spsr_d       = spsr_q;
    if (legal_enter) begin
      state_d = ST_EXC;
      spsr_d  = flags_wr;
    end else if (legal_return) begin
      state_d = ST_NORMAL;
      cpsr_d  = spsr_q;
    end
  end

  always_comb begin
    cpsr_out = cpsr_q;
    spsr_out = spsr_q;
    in_exc   = (state_q == ST_EXC);
    exc_err  = err_q;
`ifdef CPSR_FWD_EN
    cpsr_fwd = cpsr_d;
`else
    cpsr_fwd = cpsr_q;
`endif
  end

endmodule

// File: tb/tb_cpsr_unit.sv
// Bench for cpsr_unit: a table of per-cycle vectors followed by random ALU flag writes
// checked against an independent integer model; outputs are scoreboarded through exp_q.
module tb_cpsr_unit;
  import cpsr_unit_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic         rst_n;
    logic         we;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lres;
    logic [3:0]   wdata;
    logic         enter;
    logic         ret;
    logic [3:0]   e_cpsr;
    logic [3:0]   e_spsr;
    logic         e_exc;
    logic         e_err;
    logic         chk_cond;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flag_we;
  logic [2:0]   flag_op;
  logic [W-1:0] op_a, op_b, logic_res;
  logic [3:0]   cpsr_wdata;
  logic         exc_enter, exc_return;
  logic [3:0]   cpsr_out, cpsr_fwd, spsr_out;
  logic         in_exc, exc_err;

  logic [9:0]   exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [3:0]   prev_cpsr = 4'b0000;
  logic [3:0]   prev_spsr = 4'b0000;
  vec_t         vecs[23];

  cpsr_unit #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_we    (flag_we),
    .flag_op    (flag_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .logic_res  (logic_res),
    .cpsr_wdata (cpsr_wdata),
    .exc_enter  (exc_enter),
    .exc_return (exc_return),
    .cpsr_out   (cpsr_out),
    .cpsr_fwd   (cpsr_fwd),
    .spsr_out   (spsr_out),
    .in_exc     (in_exc),
    .exc_err    (exc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic we, input logic [2:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] lres, input logic [3:0] wd,
                              input logic en, input logic rt,
                              input logic [3:0] ec, input logic [3:0] es,
                              input logic ex, input logic er, input logic cc);
    vec_t v;
    v.rst_n = r; v.we = we; v.op = op; v.a = a; v.b = b; v.lres = lres;
    v.wdata = wd; v.enter = en; v.ret = rt; v.e_cpsr = ec; v.e_spsr = es;
    v.e_exc = ex; v.e_err = er; v.chk_cond = cc;
    return v;
  endfunction

  // Independent flag model in signed/unsigned integer arithmetic.
  function automatic logic [3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [W-1:0] lres,
                                       input logic [3:0] cur);
    int ua, ub, sa, sb, s;
    logic [W-1:0] r;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    model = cur;
    if (op == FOP_ADD) begin
      r = a + b; s = sa + sb;
      model = {r[W-1], (r == '0), (ua + ub) > 65535, (s > 32767) || (s < -32768)};
    end else if (op == FOP_SUB) begin
      r = a - b; s = sa - sb;
      model = {r[W-1], (r == '0), ua >= ub, (s > 32767) || (s < -32768)};
    end else if (op == FOP_LOGIC) begin
      model = {lres[W-1], (lres == '0), cur[1], cur[0]};
    end
  endfunction

  task automatic drive_cycle(input vec_t v, input string tag);
    logic [9:0] e;
    @(negedge clk);
    rst_n = v.rst_n; flag_we = v.we; flag_op = v.op; op_a = v.a; op_b = v.b;
    logic_res = v.lres; cpsr_wdata = v.wdata; exc_enter = v.enter; exc_return = v.ret;
    #1;
    if (v.rst_n) begin
`ifdef CPSR_FWD_EN
      chk({tag, " cpsr_fwd"}, {12'h0, cpsr_fwd}, {12'h0, v.e_cpsr});
`else
      chk({tag, " cpsr_fwd"}, {12'h0, cpsr_fwd}, {12'h0, prev_cpsr});
`endif
    end
    exp_q.push_back({v.e_cpsr, v.e_spsr, v.e_exc, v.e_err});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " cpsr_out"}, {12'h0, cpsr_out}, {12'h0, e[9:6]});
    chk({tag, " spsr_out"}, {12'h0, spsr_out}, {12'h0, e[5:2]});
    chk({tag, " in_exc"},   {15'h0, in_exc},   {15'h0, e[1]});
    chk({tag, " exc_err"},  {15'h0, exc_err},  {15'h0, e[0]});
    if (v.chk_cond) begin
      chk({tag, " jge"}, {15'h0, cond_taken(COND_JGE, cpsr_out)}, 16'h1);
      chk({tag, " jgt"}, {15'h0, cond_taken(COND_JGT, cpsr_out)}, 16'h1);
    end
    prev_cpsr = v.e_cpsr;
    prev_spsr = v.e_spsr;
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 1'b0; flag_op = FOP_NONE; op_a = '0; op_b = '0;
    logic_res = '0; cpsr_wdata = '0; exc_enter = 1'b0; exc_return = 1'b0;

    //            rst we op        a        b        lres     wd       en rt  cpsr     spsr     ex er cc
    vecs[0]  = mk(0, 0, FOP_NONE,  16'h0,   16'h0,   16'h0,   4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    vecs[1]  = mk(1, 1, FOP_SUB,   16'h5,   16'h3,   16'h0,   4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 0, 1);
    vecs[2]  = mk(1, 1, FOP_ADD,   16'h7FFF,16'h1,   16'h0,   4'b0000, 0, 0, 4'b1001, 4'b0000, 0, 0, 0);
    vecs[3]  = mk(1, 1, FOP_ADD,   16'hFFFF,16'h1,   16'h0,   4'b0000, 0, 0, 4'b0110, 4'b0000, 0, 0, 0);
    vecs[4]  = mk(1, 1, FOP_LOAD,  16'h0,   16'h0,   16'h0,   4'b0011, 0, 0, 4'b0011, 4'b0000, 0, 0, 0);
    vecs[5]  = mk(1, 1, FOP_LOGIC, 16'h0,   16'h0,   16'h8000,4'b0000, 0, 0, 4'b1011, 4'b0000, 0, 0, 0);
    vecs[6]  = mk(1, 1, FOP_LOAD,  16'h0,   16'h0,   16'h0,   4'b1111, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    vecs[7]  = mk(1, 0, FOP_ADD,   16'h1,   16'h1,   16'h0,   4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    vecs[8]  = mk(1, 1, FOP_NONE,  16'h1,   16'h1,   16'h0,   4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    vecs[9]  = mk(1, 1, 3'd5,      16'h1,   16'h1,   16'h0,   4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    vecs[10] = mk(1, 1, FOP_LOAD,  16'h0,   16'h0,   16'h0,   4'b0100, 0, 0, 4'b0100, 4'b0000, 0, 0, 0);
    vecs[11] = mk(1, 0, FOP_NONE,  16'h0,   16'h0,   16'h0,   4'b0000, 1, 0, 4'b0100, 4'b0100, 1, 0, 0);
    vecs[12] = mk(1, 1, FOP_SUB,   16'h1,   16'h2,   16'h0,   4'b0000, 0, 0, 4'b1000, 4'b0100, 1, 0, 0);
    vecs[13] = mk(1, 0, FOP_NONE,  16'h0,   16'h0,   16'h0,   4'b0000, 1, 0, 4'b1000, 4'b0100, 1, 1, 0);
    vecs[14] = mk(1, 0, FOP_NONE,  16'h0,   16'h0,   16'h0,   4'b0000, 0, 0, 4'b1000, 4'b0100, 1, 0, 0);
    vecs[15] = mk(1, 1, FOP_LOAD,  16'h0,   16'h0,   16'h0,   4'b1111, 0, 1, 4'b0100, 4'b0100, 0, 0, 0);
    vecs[16] = mk(1, 0, FOP_NONE,  16'h0,   16'h0,   16'h0,   4'b0000, 0, 1, 4'b0100, 4'b0100, 0, 1, 0);
    vecs[17] = mk(1, 1, FOP_LOAD,  16'h0,   16'h0,   16'h0,   4'b0001, 1, 1, 4'b0001, 4'b0100, 0, 1, 0);
    vecs[18] = mk(1, 1, FOP_LOAD,  16'h0,   16'h0,   16'h0,   4'b1010, 1, 0, 4'b1010, 4'b1010, 1, 0, 0);
    vecs[19] = mk(0, 1, FOP_ADD,   16'h7FFF,16'h1,   16'h0,   4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    vecs[20] = mk(1, 1, FOP_SUB,   16'h3,   16'h5,   16'h0,   4'b0000, 0, 0, 4'b1000, 4'b0000, 0, 0, 0);
    vecs[21] = mk(1, 1, FOP_SUB,   16'h8000,16'h1,   16'h0,   4'b0000, 0, 0, 4'b0011, 4'b0000, 0, 0, 0);
    vecs[22] = mk(1, 1, FOP_LOGIC, 16'h0,   16'h0,   16'h0,   4'b0000, 0, 0, 4'b0111, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      drive_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      logic [2:0]   op;
      logic [W-1:0] a, b, lr;
      op = 3'($urandom_range(1, 3));
      a  = W'($urandom_range(0, 65535));
      b  = W'($urandom_range(0, 65535));
      lr = (i % 5 == 0) ? '0 : W'($urandom_range(0, 65535));
      v  = mk(1, 1, op, a, b, lr, 4'b0000, 0, 0, model(op, a, b, lr, prev_cpsr),
              prev_spsr, 0, 0, 0);
      drive_cycle(v, $sformatf("rnd%0d", i));
    end

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpsr_unit.md
CPSR_UNIT -- requirements
Module: cpsr_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, ALU operand width.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port flag_we, input, 1, flag update request this cycle.
REQ-005 SHALL have port flag_op, input, 3, flag-setting class: FOP_NONE=0, FOP_ADD=1, FOP_SUB=2, FOP_LOGIC=3, FOP_LOAD=4.
REQ-006 SHALL have ports op_a and op_b, input, DATA_W, ALU operands (ADD/SUB).
REQ-007 SHALL have port logic_res, input, DATA_W, logic result (FOP_LOGIC).
REQ-008 SHALL have port cpsr_wdata, input, 4, direct flag value (FOP_LOAD).
REQ-009 SHALL have port exc_enter, input, 1, exception entry pulse.
REQ-010 SHALL have port exc_return, input, 1, exception return pulse.
REQ-011 SHALL have port cpsr_out, output, 4, registered flags {N,Z,C,V}, bit3..bit0; feeds the branch condition checker.
REQ-012 SHALL have port cpsr_fwd, output, 4, next-cycle flag value for same-cycle branch resolution.
REQ-013 SHALL have port spsr_out, output, 4, saved flags.
REQ-014 SHALL have port in_exc, output, 1, high while in exception state.
REQ-015 SHALL have port exc_err, output, 1, one-cycle pulse on illegal exception event.

Function
REQ-016 SHALL update cpsr_out on the clk edge after flag_we=1; latency 1 cycle; flag_we=0 or FOP_NONE holds the value.
REQ-017 SHALL apply FOP_ADD as r=op_a+op_b (DATA_W+1 bits): N=r[DATA_W-1]; Z=(r[DATA_W-1:0]==0); C=r[DATA_W]; V=(a_msb==b_msb)&&(r_msb!=a_msb).
REQ-018 SHALL apply FOP_SUB as r=op_a-op_b: N, Z as ADD; C=1 when op_a>=op_b unsigned (no borrow); V=(a_msb!=b_msb)&&(r_msb!=a_msb).
REQ-019 SHALL apply FOP_LOGIC as N=logic_res MSB and Z=(logic_res==0), with C and V preserved.
REQ-020 SHALL apply FOP_LOAD as cpsr_wdata copied verbatim; codes 5..7 SHALL behave as FOP_NONE.
REQ-021 SHALL implement an FSM: NORMAL --exc_enter--> EXC: spsr<=cpsr_out, in_exc<=1; EXC --exc_return--> NORMAL: cpsr<=spsr, in_exc<=0.
REQ-022 SHALL ignore exc_enter in EXC and exc_return in NORMAL, pulsing exc_err for 1 cycle with no state change.
REQ-023 SHALL resolve simultaneous exc_enter and exc_return as exc_err with no state change, and flag_we still honoured.
REQ-024 SHALL let exc_return take priority over flag_we in the same cycle, restoring spsr.
REQ-025 SHALL, on exc_enter with flag_we in the same cycle, write the newly computed flags into both spsr and cpsr.
REQ-026 SHALL keep spsr unchanged except on legal exc_enter.

Reset
REQ-027 SHALL, with rst_n=0 at a clk edge, set cpsr_out=0000, spsr_out=0000, in_exc=0, exc_err=0 and FSM=NORMAL; reset overrides all inputs, including mid-exception.

Configuration
REQ-028 SHALL provide forwarding under macro CPSR_FWD_EN: defined, cpsr_fwd equals the value cpsr_out takes at the next edge (combinational, includes exc_return restore); undefined, cpsr_fwd=cpsr_out and branch users must wait one cycle after a flag write.

Structure
REQ-029 SHALL place FOP_* codes and flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) in the shared defines file alongside COND_* codes.
REQ-030 SHALL place the combinational flag arithmetic in sub-module flag_calc, instantiated once; the FSM and registers stay in cpsr_unit.

Verification
REQ-031 SHALL cover: FOP_SUB 0x0005-0x0003 -> cpsr_out=0010 next cycle; with condChecker, JGE and JGT taken.
REQ-032 SHALL cover: FOP_ADD 0x7FFF+0x0001 -> 1001; FOP_ADD 0xFFFF+0x0001 -> 0110.
REQ-033 SHALL cover: cpsr=0011, FOP_LOGIC logic_res=0x8000 -> 1011 (C, V kept); FOP_LOAD 1111 -> 1111.
REQ-034 SHALL cover: cpsr=0100, exc_enter, FOP_SUB 1-2 in handler -> 1000; exc_return -> cpsr=0100, in_exc=0.
REQ-035 SHALL cover: exc_return in NORMAL -> exc_err 1 cycle with state unchanged; rst_n=0 while in EXC -> all outputs 0.
REQ-036 SHALL cover: with CPSR_FWD_EN, flag_we FOP_LOAD 0100 -> cpsr_fwd=0100 same cycle while cpsr_out is still old; without the macro, cpsr_fwd tracks cpsr_out.
